// File: rtl/comparator_arbiter.sv
// Round-robin arbiter sharing one unsigned magnitude comparator between NREQ requesters.
// Each operation runs capture (IDLE) -> compare (CMP) -> respond (RESP).
module comparator_arbiter #(
    parameter int WIDTH = 4,
    parameter int NREQ  = 4,
    localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic [NREQ-1:0]       req_ready,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic                  rsp_less,
    output logic                  rsp_greater,
    output logic                  rsp_equal,
    output logic                  busy,
    output logic [7:0]            op_count
);

    typedef enum logic [1:0] {IDLE, CMP, RESP} state_t;

    state_t           state_q, state_d;
    logic [IDW-1:0]   last_grant_q, last_grant_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [IDW-1:0]   cap_id_q, cap_id_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0]   rsp_id_q, rsp_id_d;
    logic             rsp_less_q, rsp_less_d;
    logic             rsp_greater_q, rsp_greater_d;
    logic             rsp_equal_q, rsp_equal_d;
    logic [7:0]       op_count_q, op_count_d;

    logic             found;
    logic [IDW-1:0]   win_id;
    logic [NREQ-1:0]  grant;
    logic             req_hs;
    int               idx;

    // Round-robin scan starting just after the most recently served requester.
    always_comb begin
        found  = 1'b0;
        win_id = '0;
        idx    = 0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(last_grant_q) + k) % NREQ;
            if (!found && req_valid[idx]) begin
                found  = 1'b1;
                win_id = IDW'(idx);
            end
        end
    end

    // Grant is masked by reset so req_ready drops the moment rst_n falls.
    always_comb begin
        grant = '0;
        if (rst_n && state_q == IDLE && found) begin
            grant[win_id] = 1'b1;
        end
    end

    assign req_hs = |(req_valid & grant);

    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        a_d           = a_q;
        b_d           = b_q;
        cap_id_d      = cap_id_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_id_d      = rsp_id_q;
        rsp_less_d    = rsp_less_q;
        rsp_greater_d = rsp_greater_q;
        rsp_equal_d   = rsp_equal_q;
        op_count_d    = op_count_q;
        case (state_q)
            IDLE: begin
                if (req_hs) begin
                    a_d      = req_a[win_id*WIDTH +: WIDTH];
                    b_d      = req_b[win_id*WIDTH +: WIDTH];
                    cap_id_d = win_id;
                    state_d  = CMP;
                end
            end
            CMP: begin
                rsp_less_d    = (a_q <  b_q);
                rsp_greater_d = (a_q >  b_q);
                rsp_equal_d   = (a_q == b_q);
                rsp_id_d      = cap_id_q;
                rsp_valid_d   = 1'b1;
                state_d       = RESP;
            end
            RESP: begin
                if (rsp_valid_q && rsp_ready) begin
                    rsp_valid_d  = 1'b0;
                    last_grant_d = rsp_id_q;
                    op_count_d   = op_count_q + 8'd1;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Captured operands are plain data and need no reset.
    always_ff @(posedge clk) begin
        a_q      <= a_d;
        b_q      <= b_d;
        cap_id_q <= cap_id_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            last_grant_q  <= IDW'(NREQ - 1);
            rsp_valid_q   <= 1'b0;
            rsp_id_q      <= '0;
            rsp_less_q    <= 1'b0;
            rsp_greater_q <= 1'b0;
            rsp_equal_q   <= 1'b0;
            op_count_q    <= 8'd0;
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_id_q      <= rsp_id_d;
            rsp_less_q    <= rsp_less_d;
            rsp_greater_q <= rsp_greater_d;
            rsp_equal_q   <= rsp_equal_d;
            op_count_q    <= op_count_d;
        end
    end

    assign req_ready   = grant;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_id      = rsp_id_q;
    assign rsp_less    = rsp_less_q;
    assign rsp_greater = rsp_greater_q;
    assign rsp_equal   = rsp_equal_q;
    assign busy        = (state_q != IDLE);
    assign op_count    = op_count_q;

endmodule

// File: tb/tb_comparator_arbiter.sv
// Directed bench for comparator_arbiter: reset, compare outcomes, round-robin order,
// backpressure hold and op_count wrap, each against hand-computed values.
module tb_comparator_arbiter;

    localparam int WIDTH = 4;
    localparam int NREQ  = 4;
    localparam int IDW   = 2;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic [NREQ-1:0]       req_ready;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [IDW-1:0]        rsp_id;
    logic                  rsp_less;
    logic                  rsp_greater;
    logic                  rsp_equal;
    logic                  busy;
    logic [7:0]            op_count;

    int n_chk  = 0;
    int n_pass = 0;
    logic [7:0] exp_cnt;

    comparator_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_less(rsp_less), .rsp_greater(rsp_greater), .rsp_equal(rsp_equal),
        .busy(busy), .op_count(op_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // rsp flags packed as {less, greater, equal}
    task automatic check_rsp(input string tag, input int id, input logic [2:0] lge);
        check({tag, "_valid"}, 32'(rsp_valid), 32'd1);
        check({tag, "_id"}, 32'(rsp_id), 32'(id));
        check({tag, "_lge"}, 32'({rsp_less, rsp_greater, rsp_equal}), 32'(lge));
    endtask

    // One full operation from a single requester with rsp_ready held high.
    task automatic do_op(input string tag, input int id, input logic [3:0] a,
                         input logic [3:0] b, input logic [2:0] lge);
        rsp_ready = 1'b1;
        req_valid = '0;
        req_valid[id] = 1'b1;
        req_a[id*WIDTH +: WIDTH] = a;
        req_b[id*WIDTH +: WIDTH] = b;
        #1;
        check({tag, "_grant"}, 32'(req_ready), 32'(1 << id));
        tick();
        req_valid = '0;
        req_a = '1;
        req_b = '0;
        #1;
        check({tag, "_cmp_busy"}, 32'(busy), 32'd1);
        check({tag, "_cmp_novalid"}, 32'(rsp_valid), 32'd0);
        tick();
        check_rsp(tag, id, lge);
        tick();
        exp_cnt = exp_cnt + 8'd1;
        check({tag, "_idle"}, 32'(busy), 32'd0);
        check({tag, "_cnt"}, 32'(op_count), 32'(exp_cnt));
    endtask

    logic [3:0] fa [4] = '{4'h1, 4'h9, 4'hC, 4'h0};
    logic [3:0] fb [4] = '{4'h2, 4'h9, 4'h3, 4'hF};
    logic [2:0] fe [4] = '{3'b100, 3'b001, 3'b010, 3'b100};

    initial begin
        rst_n     = 1'b0;
        req_valid = '1;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
        exp_cnt   = 8'd0;
        #2;
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_valid", 32'(rsp_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_cnt", 32'(op_count), 32'd0);
        check("rst_flags", 32'({rsp_less, rsp_greater, rsp_equal, rsp_id}), 32'd0);
        req_valid = '0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        do_op("single", 0, 4'hE, 4'hF, 3'b100);
        do_op("greater", 2, 4'hE, 4'h5, 3'b010);
        do_op("equal", 2, 4'hE, 4'hE, 3'b001);

        // Backpressure: response must hold while rsp_ready is low.
        rsp_ready = 1'b0;
        req_valid = 4'b0010;
        req_a[1*WIDTH +: WIDTH] = 4'h7;
        req_b[1*WIDTH +: WIDTH] = 4'h3;
        #1;
        check("bp_grant", 32'(req_ready), 32'b0010);
        tick();
        req_valid = '1;
        req_a = '0;
        req_b = '1;
        tick();
        for (int i = 0; i < 5; i++) begin
            check_rsp("bp_hold", 1, 3'b010);
            check("bp_ready", 32'(req_ready), 32'd0);
            check("bp_busy", 32'(busy), 32'd1);
            tick();
        end
        check("bp_cnt_held", 32'(op_count), 32'(exp_cnt));
        rsp_ready = 1'b1;
        tick();
        exp_cnt = exp_cnt + 8'd1;
        check("bp_released", 32'(rsp_valid), 32'd0);
        check("bp_idle", 32'(busy), 32'd0);
        check("bp_cnt", 32'(op_count), 32'(exp_cnt));
        check("bp_next_rr", 32'(req_ready), 32'b0100);
        req_valid = '0;
        tick();

        // Asynchronous reset while a response is pending.
        rsp_ready = 1'b0;
        req_valid = 4'b1000;
        req_a[3*WIDTH +: WIDTH] = 4'h2;
        req_b[3*WIDTH +: WIDTH] = 4'h2;
        tick();
        req_valid = '0;
        tick();
        check_rsp("pre_rst", 3, 3'b001);
        #2;
        rst_n = 1'b0;
        #1;
        exp_cnt = 8'd0;
        check("arst_valid", 32'(rsp_valid), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_cnt", 32'(op_count), 32'd0);
        tick();
        rst_n = 1'b1;

        // Fairness: all requesters valid, grants rotate starting at 0.
        rsp_ready = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*WIDTH +: WIDTH] = fa[i];
            req_b[i*WIDTH +: WIDTH] = fb[i];
        end
        req_valid = '1;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("rr_grant", 32'(req_ready), 32'(1 << (k % NREQ)));
            tick();
            check("rr_cmp_ready", 32'(req_ready), 32'd0);
            tick();
            check_rsp("rr_rsp", k % NREQ, fe[k % NREQ]);
            tick();
            exp_cnt = exp_cnt + 8'd1;
            check("rr_cnt", 32'(op_count), 32'(exp_cnt));
        end

        // Wrap: keep requester 0 busy until 256 operations complete.
        req_valid = 4'b0001;
        repeat (3 * 250) tick();
        check("wrap_255", 32'(op_count), 32'hFF);
        repeat (3) tick();
        check("wrap_0", 32'(op_count), 32'h00);
        req_valid = '0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
